// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider: 32-bit dividend / 16-bit divisor,
// one quotient bit per cycle, start/done handshake with busy stall indication.
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    localparam int unsigned DW = 32;
    localparam int unsigned VW = 16;
    localparam int unsigned CW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state, state_n;
    logic [DW-1:0] dq, dq_n;
    logic [VW-1:0] p, p_n;
    logic [VW-1:0] dvsr, dvsr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          busy_n, done_n, dbz_n;
    logic [DW-1:0] quotient_n;
    logic [VW-1:0] remainder_n;
    logic [VW:0]   p_sh;

    // Settled remainders are always below the divisor, so only 16 bits are stored;
    // the 17th bit exists only in the shifted trial value.
    always_comb begin
        state_n     = state;
        dq_n        = dq;
        p_n         = p;
        dvsr_n      = dvsr;
        cnt_n       = cnt;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;
        p_sh        = {p, dq[DW-1]};

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_n = RUN;
                        dq_n    = dividend;
                        dvsr_n  = divisor;
                        p_n     = '0;
                        cnt_n   = '0;
                    end else begin
                        state_n     = DONE;
                        quotient_n  = '1;
                        remainder_n = dividend[VW-1:0];
                        dbz_n       = 1'b1;
                        done_n      = 1'b1;
                    end
                end
            end
            RUN: begin
                if (p_sh >= {1'b0, dvsr}) begin
                    p_n  = VW'(p_sh - {1'b0, dvsr});
                    dq_n = {dq[DW-2:0], 1'b1};
                end else begin
                    p_n  = p_sh[VW-1:0];
                    dq_n = {dq[DW-2:0], 1'b0};
                end
                cnt_n = CW'(cnt + CW'(1));
                if (cnt == CW'(DW - 1)) begin
                    state_n     = DONE;
                    quotient_n  = dq_n;
                    remainder_n = p_n;
                    dbz_n       = 1'b0;
                    done_n      = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= '0;
            p           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            dq          <= dq_n;
            p           <= p_n;
            dvsr        <= dvsr_n;
            cnt         <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized back-to-back
// divisions checked against plain integer division.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with a one-cycle start pulse; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Wait (bounded) for done, then compare against arithmetic reference results.
    task automatic wait_done(input string tag, input logic [31:0] a, input logic [15:0] b,
                             input int lat0);
        int          lat;
        int          elat;
        bit          busy_bad;
        logic [31:0] eq;
        logic [15:0] er;
        lat      = lat0;
        busy_bad = 1'b0;
        if (b == 16'd0) begin
            eq   = 32'hFFFF_FFFF;
            er   = a[15:0];
            elat = 0;
        end else begin
            eq   = a / {16'd0, b};
            er   = 16'(a % {16'd0, b});
            elat = 32;
        end
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(b == 16'd0));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_busy_during_run"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        logic [31:0] a, na;
        logic [15:0] b, nb, ma, mb;
        int          extra;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) step();
        chk("reset_outputs", 64'({busy, done, quotient, remainder, div_by_zero}), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic divide
        issue(32'd100, 16'd7);
        chk("basic_busy_after_accept", 64'(busy), 64'd1);
        wait_done("basic", 32'd100, 16'd7, 0);
        chk("basic_q_literal", 64'(quotient), 64'd14);
        chk("basic_r_literal", 64'(remainder), 64'd2);
        step();
        chk("basic_done_one_cycle", 64'(done), 64'd0);

        // Full range
        issue(32'hFFFF_FFFF, 16'hFFFF);
        wait_done("full_max", 32'hFFFF_FFFF, 16'hFFFF, 0);
        chk("full_max_q_literal", 64'(quotient), 64'h0001_0001);
        step();
        issue(32'hFFFF_FFFF, 16'd1);
        wait_done("full_div1", 32'hFFFF_FFFF, 16'd1, 0);
        step();

        // Divide by zero
        issue(32'h0001_2345, 16'd0);
        wait_done("dbz", 32'h0001_2345, 16'd0, 0);
        chk("dbz_r_literal", 64'(remainder), 64'h2345);
        step();
        chk("dbz_done_falls", 64'(done), 64'd0);
        chk("dbz_q_held", 64'(quotient), 64'hFFFF_FFFF);
        chk("dbz_flag_held", 64'(div_by_zero), 64'd1);

        // Start while busy is ignored
        issue(32'd1000, 16'd10);
        repeat (9) step();
        dividend = 32'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_done("start_busy", 32'd1000, 16'd10, 10);
        extra = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) extra++;
        end
        chk("start_busy_no_second_done", 64'(extra), 64'd0);

        // Reset mid-operation
        issue(32'd1000, 16'd3);
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", 64'({busy, done, quotient, remainder, div_by_zero}), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        issue(32'd1000, 16'd3);
        wait_done("after_reset", 32'd1000, 16'd3, 0);
        chk("after_reset_q_literal", 64'(quotient), 64'd333);
        step();

        // Random back-to-back divisions, start issued in each done cycle
        a = $urandom;
        b = 16'($urandom_range(1, 65535));
        issue(a, b);
        for (int i = 0; i < 10; i++) begin
            wait_done($sformatf("rand%0d", i), a, b, 0);
            if (i < 9) begin
                na = $urandom;
                if (i == 3)          nb = 16'd0;
                else if (i % 3 == 0) nb = 16'($urandom_range(1, 15));
                else                 nb = 16'($urandom_range(1, 65535));
                issue(na, nb);
                a = na;
                b = nb;
            end
        end
        step();
        chk("rand_done_falls", 64'(done), 64'd0);

        // Multiply then divide round trip, back-to-back
        ma = 16'($urandom);
        mb = 16'($urandom_range(1, 65535));
        issue({16'd0, ma} * {16'd0, mb}, mb);
        for (int i = 0; i < 6; i++) begin
            wait_done($sformatf("trip%0d", i), {16'd0, ma} * {16'd0, mb}, mb, 0);
            chk($sformatf("trip%0d_q_is_a", i), 64'(quotient), 64'(ma));
            if (i < 5) begin
                ma = 16'($urandom);
                mb = 16'($urandom_range(1, 65535));
                issue({16'd0, ma} * {16'd0, mb}, mb);
            end
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
